toggle_ctrl: RTL and testbench

TOGGLE_CTRL -- requirements
Module: toggle_ctrl

---
 rtl/toggle_ctrl.sv | 143 ++++++++++++++
 tb/tb_toggle_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_ctrl.sv
// toggle_ctrl: programmable square-wave generator. Produces bursts of q toggles
// spaced cfg_div cycles apart, or a continuous toggle stream when cfg_count is 0.
// Latency: start at edge k gives the first q change at edge k+N; tick/done are registered.
// Backpressure: config is accepted only while cfg_ready (IDLE); start/stop are ignored when not applicable.
//
// Ports:
//   clk, reset              clock, async active-high reset
//   cfg_valid/cfg_ready     config handshake carrying cfg_div (N) and cfg_count (0 = continuous)
//   start, stop             single-cycle run control
//   pause                   level; freezes the prescaler while high
//   q, tick, busy, done     toggle output, post-toggle pulse, running flag, burst-complete pulse
module toggle_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic             q,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic terminal;
  logic advance;

  // div_q is never 0, so div_q-1 is always a valid terminal count.
  assign terminal = (pre_q == (div_q - DIV_ONE));

  // The prescaler steps on every busy cycle with pause low. In RUN a terminal
  // count still completes when pause rises, so the toggle lands before PAUSE.
  always_comb begin
    advance = 1'b0;
    if (state_q == RUN)   advance = !pause || terminal;
    if (state_q == PAUSE) advance = !pause;
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          div_d = (cfg_div == '0) ? DIV_ONE : cfg_div;
          cnt_d = cfg_count;
        end
        if (start) begin
          state_d = RUN;
          pre_d   = '0;
          q_d     = 1'b0;
          // A config offered alongside start belongs to this run.
          rem_d   = cfg_valid ? cfg_count : cnt_q;
        end
      end

      RUN, PAUSE: begin
        state_d = pause ? PAUSE : RUN;
        if (advance) begin
          if (terminal) begin
            pre_d  = '0;
            q_d    = ~q_q;
            tick_d = 1'b1;
            // Finite burst: count down; the last toggle ends the run.
            if (cnt_q != '0 && rem_q != '0) begin
              rem_d = rem_q - CNT_ONE;
              if (rem_q == CNT_ONE) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end else begin
            pre_d = pre_q + DIV_ONE;
          end
        end
        // Any toggle due this cycle still happens; stop only prevents later ones.
        if (stop) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      rem_q   <= '0;
      div_q   <= DIV_ONE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign q         = q_q;
  assign tick      = tick_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign cfg_ready = (state_q == IDLE);

endmodule

// File: tb/tb_toggle_ctrl.sv
// tb_toggle_ctrl: scenario tasks plus a randomized run, checked against a
// cycle-level behavioural model of the toggle generator.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_toggle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_div = '0;
  logic [7:0]  cfg_count = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        q, tick, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  toggle_ctrl #(.DIV_W(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_count(cfg_count),
    .start(start), .stop(stop), .pause(pause),
    .q(q), .tick(tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model: counts active cycles since the last toggle and the
  // number of toggles made in the current run.
  int m_div, m_cnt, m_elapsed, m_toggles;
  bit m_busy, m_paused, m_q, m_tick, m_done;

  task automatic model_reset();
    m_div = 1; m_cnt = 0; m_elapsed = 0; m_toggles = 0;
    m_busy = 0; m_paused = 0; m_q = 0; m_tick = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit active;
    m_tick = 0;
    m_done = 0;
    if (!m_busy) begin
      if (cfg_valid) begin
        m_div = (cfg_div == 0) ? 1 : int'(cfg_div);
        m_cnt = int'(cfg_count);
      end
      if (start) begin
        m_busy = 1; m_paused = 0; m_elapsed = 0; m_toggles = 0; m_q = 0;
      end
    end else begin
      // Pause freezes time, except that a toggle already due while running goes ahead.
      active = !pause || (!m_paused && (m_elapsed + 1 == m_div));
      if (active) begin
        m_elapsed++;
        if (m_elapsed == m_div) begin
          m_elapsed = 0;
          m_q = !m_q;
          m_tick = 1;
          m_toggles++;
          if (m_cnt != 0 && m_toggles == m_cnt) begin
            m_done = 1;
            m_busy = 0;
          end
        end
      end
      if (stop) m_busy = 0;
      m_paused = pause;
    end
  endtask

  function automatic logic [4:0] exp_vec();
    return {m_q, m_tick, m_busy, m_done, !m_busy};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    cfg_valid = 0; cfg_div = '0; cfg_count = '0; start = 0; stop = 0; pause = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({q, tick, busy, done, cfg_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_hold got %b want 00001", {q, tick, busy, done, cfg_ready});
    end
    reset = 0;
    step();
    checks++;
    if ({q, tick, busy, done, cfg_ready} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got %b want %b", {q, tick, busy, done, cfg_ready}, exp_vec());
    end
  endtask

  task automatic test_burst();
    int tick_at[$];
    int done_at;
    int exp_at[4] = '{3, 6, 9, 12};
    done_at = -1;
    clear_inputs();
    cfg_valid = 1; cfg_div = 16'd3; cfg_count = 8'd4;
    step();
    cfg_valid = 0; start = 1;
    step();
    start = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      checks++;
      if ({q, tick, busy, done, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL burst_cyc%0d got %b want %b", i, {q, tick, busy, done, cfg_ready}, exp_vec());
      end
      if (tick) tick_at.push_back(i);
      if (done) done_at = i;
    end
    checks++;
    if (tick_at.size() != 4) begin
      errors++;
      $display("FAIL burst_tick_count got %0d want 4", tick_at.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (tick_at[j] != exp_at[j]) begin
          errors++;
          $display("FAIL burst_tick%0d_offset got %0d want %0d", j, tick_at[j], exp_at[j]);
        end
      end
    end
    checks++;
    if (done_at != 12) begin
      errors++;
      $display("FAIL burst_done_offset got %0d want 12", done_at);
    end
    checks++;
    if ({q, busy, cfg_ready} !== 3'b001) begin
      errors++;
      $display("FAIL burst_final got q/busy/rdy=%b want 001", {q, busy, cfg_ready});
    end
  endtask

  task automatic test_continuous();
    int ticks, dones;
    ticks = 0; dones = 0;
    clear_inputs();
    cfg_valid = 1; cfg_div = 16'd1; cfg_count = 8'd0;
    step();
    cfg_valid = 0; start = 1;
    step();
    start = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) stop = 1;
      step();
      stop = 0;
      checks++;
      if ({q, tick, busy, done, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL cont_cyc%0d got %b want %b", i, {q, tick, busy, done, cfg_ready}, exp_vec());
      end
      ticks += int'(tick);
      dones += int'(done);
    end
    checks++;
    if (ticks != 10 || dones != 0) begin
      errors++;
      $display("FAIL cont_counts got ticks=%0d done=%0d want ticks=10 done=0", ticks, dones);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({q, tick, busy, done, cfg_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL cont_held%0d got %b want 00001", i, {q, tick, busy, done, cfg_ready});
      end
    end
  endtask

  task automatic test_pause();
    int first_tick, ticks_in_pause;
    first_tick = -1; ticks_in_pause = 0;
    clear_inputs();
    cfg_valid = 1; cfg_div = 16'd4; cfg_count = 8'd2;
    step();
    cfg_valid = 0; start = 1;
    step();
    start = 0;
    for (int i = 1; i <= 16; i++) begin
      pause = (i >= 3 && i <= 7);
      step();
      checks++;
      if ({q, tick, busy, done, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL pause_cyc%0d got %b want %b", i, {q, tick, busy, done, cfg_ready}, exp_vec());
      end
      if (pause && tick) ticks_in_pause++;
      if (tick && first_tick < 0) first_tick = i;
    end
    pause = 0;
    checks++;
    if (first_tick != 9) begin
      errors++;
      $display("FAIL pause_first_toggle got %0d want 9", first_tick);
    end
    checks++;
    if (ticks_in_pause != 0) begin
      errors++;
      $display("FAIL pause_no_tick got %0d want 0", ticks_in_pause);
    end
  endtask

  task automatic test_stop_final();
    clear_inputs();
    cfg_valid = 1; cfg_div = 16'd2; cfg_count = 8'd1;
    step();
    cfg_valid = 0; start = 1;
    step();
    start = 0;
    step();
    stop = 1;
    step();
    stop = 0;
    checks++;
    if ({q, tick, busy, done, cfg_ready} !== 5'b11011) begin
      errors++;
      $display("FAIL stop_final got %b want 11011", {q, tick, busy, done, cfg_ready});
    end
    step();
    checks++;
    if ({q, tick, busy, done, cfg_ready} !== 5'b10001) begin
      errors++;
      $display("FAIL stop_final_after got %b want 10001", {q, tick, busy, done, cfg_ready});
    end
  endtask

  task automatic test_div_zero_and_ignore();
    int ticks;
    ticks = 0;
    clear_inputs();
    cfg_valid = 1; cfg_div = 16'd0; cfg_count = 8'd0; start = 1;
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      ticks += int'(tick);
    end
    cfg_valid = 1; cfg_div = 16'd7; cfg_count = 8'd3;
    step();
    ticks += int'(tick);
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      step();
      ticks += int'(tick);
      checks++;
      if ({q, tick, busy, done, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL ignore_cyc%0d got %b want %b", i, {q, tick, busy, done, cfg_ready}, exp_vec());
      end
    end
    checks++;
    if (ticks != 8) begin
      errors++;
      $display("FAIL div0_ticks got %0d want 8", ticks);
    end
    stop = 1;
    step();
    stop = 0;
    // Restart without a new config: the ignored div 7 must not have been latched.
    start = 1;
    step();
    start = 0;
    ticks = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      ticks += int'(tick);
    end
    checks++;
    if (ticks != 4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_cfg_restart got ticks=%0d busy=%b want ticks=4 busy=1", ticks, busy);
    end
    stop = 1;
    step();
    stop = 0;
  endtask

  task automatic test_async_reset();
    int dones;
    dones = 0;
    clear_inputs();
    cfg_valid = 1; cfg_div = 16'd1; cfg_count = 8'd8;
    step();
    cfg_valid = 0; start = 1;
    step();
    start = 0;
    step();
    checks++;
    if ({q, tick, busy} !== 3'b111) begin
      errors++;
      $display("FAIL areset_pre got %b want 111", {q, tick, busy});
    end
    #2 reset = 1;
    #1;
    model_reset();
    checks++;
    if ({q, tick, busy, done, cfg_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL areset_immediate got %b want 00001", {q, tick, busy, done, cfg_ready});
    end
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      dones += int'(done);
      checks++;
      if ({q, tick, busy, done, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL areset_after%0d got %b want %b", i, {q, tick, busy, done, cfg_ready}, exp_vec());
      end
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL areset_no_done got %0d want 0", dones);
    end
  endtask

  task automatic test_random();
    clear_inputs();
    for (int i = 0; i < 800; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_div   = 16'($urandom_range(0, 4));
      cfg_count = 8'($urandom_range(0, 4));
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 5) == 0) pause = !pause;
      step();
      checks++;
      if ({q, tick, busy, done, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL random_cyc%0d got %b want %b", i, {q, tick, busy, done, cfg_ready}, exp_vec());
      end
    end
    clear_inputs();
    stop = 1;
    step();
    stop = 0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL random_final_stop got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_continuous();
    test_pause();
    test_stop_final();
    test_div_zero_and_ignore();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
